// File: rtl/uart_apb_pkg.sv
// uart_apb_pkg: types and constants shared by the UART APB initiator, the
// UART top and its testbench.
//   apb_state_e      : initiator FSM states (IDLE, SETUP, ACCESS, RESP)
//   UART_ADDR_DIVXR  : baud divisor register address
//   UART_ADDR_TXFIFO : TX FIFO (write) / RX FIFO (read) data address
package uart_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int unsigned UART_ADDR_DIVXR  = 1;
  localparam int unsigned UART_ADDR_TXFIFO = 2;

endpackage

// File: rtl/uart_apb_master.sv
// uart_apb_master: turns one command handshake into one APB transfer
// (SETUP, then ACCESS held until PREADY) and returns read data / error
// status on a response handshake. At most one transfer is outstanding.
//
// Optional feature: define UART_APB_MST_TIMEOUT_EN to end an ACCESS phase
// after TO_CYCLES cycles without PREADY (rsp_err=1, rsp_timeout=1).
//
// Ports:
//   clk, rst                      : clock, synchronous active-low reset
//   cmd_valid/ready/write/addr/wdata : command handshake
//   rsp_valid/ready/rdata/err/timeout: response handshake
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA : APB requester outputs
//   PREADY/PRDATA/PSLVERR            : APB completer inputs
module uart_apb_master
  import uart_apb_pkg::*;
#(
  parameter int unsigned APB_DW    = 8,
  parameter int unsigned TO_CYCLES = 16,
  parameter int unsigned TO_W      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [APB_DW-1:0] cmd_addr,
  input  logic [APB_DW-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [APB_DW-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [APB_DW-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [APB_DW-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [APB_DW-1:0] PRDATA,
  input  logic              PSLVERR
);

  apb_state_e        state_q, state_d;
  logic [APB_DW-1:0] paddr_q, paddr_d;
  logic [APB_DW-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [APB_DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_to_q, rsp_to_d;
`ifdef UART_APB_MST_TIMEOUT_EN
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
`ifdef UART_APB_MST_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
`ifdef UART_APB_MST_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_to_d    = rsp_to_q;
`ifdef UART_APB_MST_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pwrite_d = cmd_write;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef UART_APB_MST_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      ACCESS: begin
        // PREADY takes priority over a timeout hitting in the same cycle.
        if (PREADY) begin
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
          rsp_to_d    = 1'b0;
          rsp_valid_d = 1'b1;
          paddr_d     = '0;
          pwdata_d    = '0;
          pwrite_d    = 1'b0;
          state_d     = RESP;
        end
`ifdef UART_APB_MST_TIMEOUT_EN
        // Limit reached when this cycle's increment would make TO_CYCLES.
        else if (to_cnt_q == TO_W'(TO_CYCLES - 1)) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_to_d    = 1'b1;
          rsp_valid_d = 1'b1;
          paddr_d     = '0;
          pwdata_d    = '0;
          pwrite_d    = 1'b0;
          state_d     = RESP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == IDLE) && rst;
  assign PSEL        = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE     = (state_q == ACCESS);
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PWRITE      = pwrite_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
`ifdef UART_APB_MST_TIMEOUT_EN
  assign rsp_timeout = rsp_to_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_apb_master.sv
// Directed testbench for uart_apb_master. Inputs are driven 1 time unit
// after each rising edge; outputs are checked at the same point.
// Timeout checks follow UART_APB_MST_TIMEOUT_EN if it is defined.
module tb_uart_apb_master;
  import uart_apb_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0, cmd_wdata = '0;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic [7:0] PADDR, PWDATA, PRDATA = '0;
  logic       PSEL, PENABLE, PWRITE, PREADY = 1'b0, PSLVERR = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;
  int psel_cycles;

  uart_apb_master #(.APB_DW(8), .TO_CYCLES(16), .TO_W(5)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    step(); step();
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_paddr", PADDR, 0);
    rst = 1'b1; #1;
    chk("idle_cmd_ready", cmd_ready, 1);

    // Write 0x36 to DIVxR, PREADY in the second ACCESS cycle
    rsp_ready = 1'b1;
    PRDATA = 8'hFF;
    cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 8'(UART_ADDR_DIVXR); cmd_wdata = 8'h36;
    psel_cycles = 0;
    step();
    cmd_valid = 1'b0;
    chk("wr_setup_psel", PSEL, 1);
    chk("wr_setup_penable", PENABLE, 0);
    chk("wr_setup_paddr", PADDR, 1);
    chk("wr_setup_pwrite", PWRITE, 1);
    chk("wr_setup_pwdata", PWDATA, 8'h36);
    if (PSEL) psel_cycles++;
    step();
    chk("wr_acc1_penable", PENABLE, 1);
    chk("wr_acc1_pwdata", PWDATA, 8'h36);
    if (PSEL) psel_cycles++;
    step();
    chk("wr_acc2_penable", PENABLE, 1);
    chk("wr_acc2_pwdata", PWDATA, 8'h36);
    chk("wr_acc2_rsp_valid", rsp_valid, 0);
    if (PSEL) psel_cycles++;
    PREADY = 1'b1;
    step();
    PREADY = 1'b0;
    if (PSEL) psel_cycles++;
    chk("wr_psel_cycles", psel_cycles, 3);
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_err", rsp_err, 0);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_rsp_timeout", rsp_timeout, 0);
    chk("wr_resp_psel", PSEL, 0);
    chk("wr_resp_paddr", PADDR, 0);
    chk("wr_resp_pwdata", PWDATA, 0);
    chk("wr_resp_cmd_ready", cmd_ready, 0);
    step();
    chk("wr_done_rsp_valid", rsp_valid, 0);
    chk("wr_done_cmd_ready", cmd_ready, 1);

    // Read addr 0 with slave error; PREADY during SETUP must be ignored
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h77;
    step();
    cmd_valid = 1'b0;
    chk("rd_setup_penable", PENABLE, 0);
    chk("rd_setup_psel", PSEL, 1);
    chk("rd_setup_pwrite", PWRITE, 0);
    PREADY = 1'b1; PRDATA = 8'hA5; PSLVERR = 1'b1;
    step();
    chk("rd_acc_penable", PENABLE, 1);
    chk("rd_acc_rsp_valid", rsp_valid, 0);
    step();
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 8'h00;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 8'hA5);
    chk("rd_rsp_err", rsp_err, 1);
    chk("rd_resp_penable", PENABLE, 0);
    step();
    chk("rd_done_rsp_valid", rsp_valid, 0);

    // Backpressure: TX FIFO write 0x41, response held 5 cycles
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 8'(UART_ADDR_TXFIFO); cmd_wdata = 8'h41;
    step();
    chk("bp_setup_paddr", PADDR, 2);
    chk("bp_setup_pwdata", PWDATA, 8'h41);
    // second command offered immediately and kept pending
    cmd_write = 1'b0; cmd_addr = 8'(UART_ADDR_DIVXR); cmd_wdata = 8'h00;
    PREADY = 1'b1;
    step();
    chk("bp_acc_penable", PENABLE, 1);
    step();
    PREADY = 1'b0;
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_rsp_err", rsp_err, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_err", rsp_err, 0);
      chk("bp_hold_rdata", rsp_rdata, 0);
      chk("bp_hold_cmd_ready", cmd_ready, 0);
      chk("bp_hold_psel", PSEL, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_release_valid", rsp_valid, 0);
    chk("bp_release_cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk("bp_cmd2_psel", PSEL, 1);
    chk("bp_cmd2_paddr", PADDR, 1);
    chk("bp_cmd2_pwrite", PWRITE, 0);

    // Reset mid-ACCESS
    step();
    chk("mr_acc_penable", PENABLE, 1);
    rst = 1'b0;
    step();
    chk("mr_psel", PSEL, 0);
    chk("mr_penable", PENABLE, 0);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_cmd_ready", cmd_ready, 0);
    rst = 1'b1; #1;
    chk("mr_idle_cmd_ready", cmd_ready, 1);
    step();
    chk("mr_no_rsp", rsp_valid, 0);

    // Long wait with no PREADY
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h03;
    step();
    cmd_valid = 1'b0;
    step();                       // first ACCESS cycle
    chk("to_entry_penable", PENABLE, 1);
    for (int i = 0; i < 15; i++) step();
    chk("to_15_rsp_valid", rsp_valid, 0);
    chk("to_15_penable", PENABLE, 1);
    step();
`ifdef UART_APB_MST_TIMEOUT_EN
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_timeout", rsp_timeout, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_psel", PSEL, 0);
    step();
`else
    chk("nto_rsp_valid", rsp_valid, 0);
    chk("nto_penable", PENABLE, 1);
    for (int i = 0; i < 10; i++) step();
    chk("nto_long_penable", PENABLE, 1);
    PREADY = 1'b1; PRDATA = 8'h5C;
    step();
    PREADY = 1'b0;
    chk("nto_rsp_valid_end", rsp_valid, 1);
    chk("nto_rsp_rdata", rsp_rdata, 8'h5C);
    chk("nto_rsp_timeout", rsp_timeout, 0);
    step();
`endif
    chk("to_back_idle", cmd_ready, 1);

    // PREADY in the 16th ACCESS cycle completes normally
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h04;
    step();
    cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 15; i++) step();
    chk("pw_16_penable", PENABLE, 1);
    PREADY = 1'b1; PRDATA = 8'h3C;
    step();
    PREADY = 1'b0;
    chk("pw_rsp_valid", rsp_valid, 1);
    chk("pw_rsp_timeout", rsp_timeout, 0);
    chk("pw_rsp_err", rsp_err, 0);
    chk("pw_rsp_rdata", rsp_rdata, 8'h3C);
    step();
    chk("pw_idle", cmd_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_apb_master.md
Name: uart_apb_master

Overview:
APB initiator that drives the UART block's APB slave port. It turns a simple command handshake (address, write flag, write data) into one APB transfer: SETUP, then ACCESS held until PREADY. It returns read data and error status on a response handshake. It sits between a host/sequencer and the UART register interface, and is used for DIVxR programming, TX FIFO writes and RX FIFO reads.

Parameters:
APB_DW, 8, width of PADDR/PWDATA/PRDATA and command/response data
TO_CYCLES, 16, ACCESS-phase wait limit in clk cycles (used only with the optional feature)
TO_W, 5, width of the timeout counter; must satisfy 2^TO_W > TO_CYCLES

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when cmd_valid&cmd_ready
cmd_write  input  1  1 = APB write, 0 = APB read
cmd_addr  input  APB_DW  target address (1 = DIVxR, 2 = TX FIFO)
cmd_wdata  input  APB_DW  write data
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when rsp_valid&rsp_ready
rsp_rdata  output  APB_DW  captured PRDATA (reads); 0 for writes
rsp_err  output  1  PSLVERR seen, or timeout
rsp_timeout  output  1  transfer ended by timeout
PADDR  output  APB_DW  APB address
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PWDATA  output  APB_DW  APB write data
PREADY  input  1  slave ready
PRDATA  input  APB_DW  slave read data
PSLVERR  input  1  slave error

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA = 0; cmd_ready=0 during reset; rsp_valid, rsp_rdata, rsp_err, rsp_timeout = 0; timeout counter = 0. Reset asserted mid-transfer aborts the transfer immediately. No response is produced for it.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1 (combinational from state). On cmd_valid, latch cmd_* into PADDR/PWRITE/PWDATA and go to SETUP; drive PSEL=1, PENABLE=0.
- SETUP: exactly one cycle. Next state is ACCESS with PENABLE=1; PSEL, PADDR, PWRITE and PWDATA stay stable.
- ACCESS: hold all APB outputs until PREADY=1. On PREADY:
  - capture PRDATA into rsp_rdata if PWRITE=0, else rsp_rdata=0;
  - rsp_err=PSLVERR;
  - drop PSEL and PENABLE; drive PADDR/PWDATA/PWRITE to 0;
  - set rsp_valid=1 and go to RESP.
- RESP: hold rsp_* stable while rsp_ready=0. On rsp_ready, clear rsp_valid and go to IDLE. cmd_ready=0 here.
- Timing: best case cmd accepted in cycle 0, PSEL in 1, PENABLE in 2, rsp_valid in the cycle after PREADY is sampled.
- The UART slave raises PREADY one cycle after it sees PENABLE, so a nominal transfer is accept, SETUP, ACCESS x2, RESP.
- Back-to-back commands: a new command is accepted only after the response handshake. There is at most one outstanding transfer.
- PREADY or PSLVERR outside ACCESS is ignored.
- rsp_ready asserted without rsp_valid has no effect.

Optional Feature:
UART_APB_MST_TIMEOUT_EN
- Defined: an ACCESS-phase counter is cleared on entry to ACCESS and increments each cycle PREADY=0. When it reaches TO_CYCLES, the transfer ends: APB outputs drop, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, and state goes to RESP. If PREADY=1 arrives in the same cycle the limit is hit, PREADY wins and the transfer completes normally.
- Not defined: no counter; ACCESS waits indefinitely; rsp_timeout is tied 0.

Decomposition:
- Shared package uart_apb_pkg:
  - state typedef (IDLE, SETUP, ACCESS, RESP);
  - address constants UART_ADDR_DIVXR=1 and UART_ADDR_TXFIFO=2.
- No sub-module needed; the timeout counter stays inline. The UART top and the bench import the same package.

Test Plan:
- Write to DIVxR: cmd write, addr=1, wdata=0x36, PREADY=1 two cycles after PENABLE -> PSEL high for 3 cycles, PWDATA=0x36 stable throughout, rsp_valid with rsp_err=0 and rsp_rdata=0.
- Read with error: cmd read, addr=0, slave returns PRDATA=0xA5 and PSLVERR=1 with PREADY -> rsp_rdata=0xA5, rsp_err=1, no PENABLE in the SETUP cycle.
- Response backpressure: rsp_ready held 0 for 5 cycles with cmd_valid=1 -> rsp_* stable, cmd_ready=0 throughout; second command is accepted the cycle after rsp_ready=1.
- Reset mid-ACCESS: rst=0 while PENABLE=1 -> next cycle PSEL=PENABLE=0, rsp_valid=0, state IDLE.
- Timeout (macro defined, TO_CYCLES=16): PREADY never asserted -> rsp_valid 16 cycles after ACCESS entry with rsp_err=1 and rsp_timeout=1. With PREADY at cycle 16 -> normal completion, rsp_timeout=0.
- Loopback with the UART top: write 0x41 to addr 2, then poll read -> TX FIFO write observed with PSLVERR=0; read with RX FIFO empty returns rsp_err=1.
